dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the load path (load RS / load queue) and the committed-store drain at the head of the store buffer.
- Issues at most one outstanding dmem transaction at a time and routes the load response back tagged with its ROB index.
- Drops load responses that are in flight across a pipeline flush.
- Guarantees forward progress for stores: a full store buffer or a starvation limit forces store priority.

Parameters:
- ROB_DEPTH, 3, width of ROB index tags
- STARVE_LIMIT, 4, consecutive load grants allowed while a store waits before the store is forced
- STARVE_W, 3, width of the starvation counter; must satisfy 2**STARVE_W > STARVE_LIMIT

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- move_flush  in  1  pipeline flush; squashes load-side state
- ld_req_valid  in  1  load request pending
- ld_req_addr  in  32  word-aligned load address
- ld_req_rmask  in  4  byte read mask; nonzero when valid
- ld_req_rob  in  ROB_DEPTH  ROB tag of the load
- ld_req_ready  out  1  load accepted this cycle
- ld_resp_valid  out  1  one-cycle pulse, load data returned
- ld_resp_rob  out  ROB_DEPTH  tag of the returned load
- ld_resp_rdata  out  32  raw dmem word
- sb_head_valid  in  1  store buffer head holds a committed store
- sb_head_addr  in  32  store address
- sb_head_wmask  in  4  byte write mask
- sb_head_wdata  in  32  lane-aligned store data
- store_buffer_full  in  1  store buffer full
- sb_pop  out  1  one-cycle pulse, store completed; pop head
- dmem_addr  out  32  memory address, word-aligned
- dmem_rmask  out  4  read mask; one-cycle pulse
- dmem_wmask  out  4  write mask; one-cycle pulse
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data
- dmem_resp  in  1  transaction done

Behaviour:
- FSM states: IDLE, LD_WAIT, ST_WAIT.
- Reset (async, rst_n=0) values:
  - state=IDLE
  - all outputs 0
  - latched address/data/tag registers 0
  - starve counter 0
  - squash flag 0
- Arbitration in IDLE, single cycle. The store wins if sb_head_valid and any of:
  - store_buffer_full
  - starve_cnt >= STARVE_LIMIT
  - !ld_req_valid
- Otherwise a valid load wins.
- Load grant:
  - ld_req_ready=1 combinationally, same cycle.
  - Latch addr and rob.
  - Drive dmem_rmask=ld_req_rmask for exactly that cycle; dmem_wmask=0.
  - Next state LD_WAIT.
- Store grant:
  - Drive dmem_wmask/wdata/addr for that cycle; dmem_rmask=0.
  - Latch addr/wdata.
  - Next state ST_WAIT.
- dmem_addr/dmem_wdata are held stable from the latched registers until dmem_resp.
- LD_WAIT on dmem_resp:
  - ld_resp_valid=!squash, with ld_resp_rob = latched tag and ld_resp_rdata=dmem_rdata.
  - Go to IDLE and clear squash.
- ST_WAIT on dmem_resp: sb_pop=1 for one cycle, then go to IDLE.
- Latency:
  - Grant to earliest response is 1 cycle (dmem_resp may arrive the cycle after the request).
  - A new grant can occur only in the cycle after return to IDLE. There is no back-to-back issue.
- Starve counter:
  - Increments on each load grant while sb_head_valid, saturating at its maximum.
  - Clears on each store grant or when !sb_head_valid.
- move_flush:
  - In IDLE: no load is granted that cycle (ld_req_ready=0). Stores may still be granted, because committed stores survive a flush.
  - In LD_WAIT: set squash. The pending response completes on dmem, but ld_resp_valid stays 0.
  - If move_flush and dmem_resp coincide in LD_WAIT, the response is suppressed.
  - In ST_WAIT: no effect, and sb_pop still fires.
- dmem_rmask and dmem_wmask are never nonzero in the same cycle.
- No request is issued while state != IDLE.

Optional Feature:
- DMEM_ARB_PERF_EN defined adds the following 32-bit saturating counters, cleared by rst_n:
  - perf_ld_grants, out 32
  - perf_st_grants, out 32
  - perf_forced_st, out 32: store grants caused by full or starvation while a load was also valid
  - perf_squashed_ld, out 32
- DMEM_ARB_PERF_EN undefined: these ports and registers do not exist.

Decomposition:
- Shared rv32i_types package gets:
  - the enum dmem_arb_state_t {IDLE, LD_WAIT, ST_WAIT}
  - a packed struct dmem_req_t {addr, rmask, wmask, wdata}
- One natural sub-module: dmem_arb_starve_ctr, the saturating starvation counter with a force_store output.

Test Plan:
- Load only: ld_req addr=0x100, rmask=0xF, rob=5; dmem_resp after 2 cycles with rdata=0xDEADBEEF -> ld_req_ready the same cycle, dmem_rmask=0xF for 1 cycle, one ld_resp_valid pulse with rob=5 and data 0xDEADBEEF.
- Simultaneous requests, buffer not full, starve=0 -> load granted first. Store granted in the IDLE cycle after the load response; sb_pop pulses once on its dmem_resp.
- Starvation: ld_req_valid and sb_head_valid held high, 1-cycle responses -> loads granted exactly 4 times, then a store with wmask=0x3, addr=0x204. Counter reads 0 afterwards.
- store_buffer_full=1 with a load valid -> store granted immediately; ld_req_ready=0 that cycle.
- Flush mid-load: move_flush in the cycle after a load grant (rob=2), resp 3 cycles later -> no ld_resp_valid. The next load is accepted normally and its response is delivered.
- Async reset asserted in ST_WAIT mid-cycle -> all outputs 0 immediately, state IDLE, and no sb_pop after release.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state, request bundle
// and a saturating-increment helper used by the optional perf counters.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } dmem_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive load grants while a committed store waits; raises
// force_store_o once the limit is reached so the store cannot starve.
module dmem_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned STARVE_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_grant_i,
  input  logic st_grant_i,
  input  logic sb_valid_i,
  output logic force_store_o
);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (st_grant_i || !sb_valid_i) begin
      cnt_d = '0;
    end else if (ld_grant_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_store_o = (32'(cnt_q) >= STARVE_LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-outstanding arbiter between the load path and the store-buffer drain.
// Optional perf counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ROB_DEPTH    = 3,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned STARVE_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 move_flush,
  input  logic                 ld_req_valid,
  input  logic [31:0]          ld_req_addr,
  input  logic [3:0]           ld_req_rmask,
  input  logic [ROB_DEPTH-1:0] ld_req_rob,
  output logic                 ld_req_ready,
  output logic                 ld_resp_valid,
  output logic [ROB_DEPTH-1:0] ld_resp_rob,
  output logic [31:0]          ld_resp_rdata,
  input  logic                 sb_head_valid,
  input  logic [31:0]          sb_head_addr,
  input  logic [3:0]           sb_head_wmask,
  input  logic [31:0]          sb_head_wdata,
  input  logic                 store_buffer_full,
  output logic                 sb_pop,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_ld_grants,
  output logic [31:0]          perf_st_grants,
  output logic [31:0]          perf_forced_st,
  output logic [31:0]          perf_squashed_ld
`endif
);

  dmem_arb_state_t     state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ROB_DEPTH-1:0] rob_q, rob_d;
  logic                squash_q, squash_d;
  logic                force_store, ld_ok, grant_ld, grant_st, ld_done, ld_deliver;
  dmem_req_t           req;

  dmem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .STARVE_W    (STARVE_W)
  ) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_grant_i   (grant_ld),
    .st_grant_i   (grant_st),
    .sb_valid_i   (sb_head_valid),
    .force_store_o(force_store)
  );

  always_comb begin
    ld_ok    = ld_req_valid && !move_flush;
    grant_st = (state_q == IDLE) && sb_head_valid &&
               (store_buffer_full || force_store || !ld_ok);
    grant_ld = (state_q == IDLE) && ld_ok && !grant_st;
    // Outside a grant cycle the port shows the latched address/data.
    req = '{addr: addr_q, rmask: '0, wmask: '0, wdata: wdata_q};
    if (grant_ld) begin
      req.addr  = ld_req_addr;
      req.rmask = ld_req_rmask;
    end else if (grant_st) begin
      req.addr  = sb_head_addr;
      req.wmask = sb_head_wmask;
      req.wdata = sb_head_wdata;
    end
  end

  assign ld_done    = (state_q == LD_WAIT) && dmem_resp;
  assign ld_deliver = ld_done && !squash_q && !move_flush;

  // Grant outputs are forced low while reset is held, even with requests pending.
  assign ld_req_ready  = grant_ld && rst_n;
  assign dmem_addr     = rst_n ? req.addr  : '0;
  assign dmem_rmask    = rst_n ? req.rmask : '0;
  assign dmem_wmask    = rst_n ? req.wmask : '0;
  assign dmem_wdata    = rst_n ? req.wdata : '0;
  assign ld_resp_valid = ld_deliver;
  assign ld_resp_rob   = ld_deliver ? rob_q : '0;
  assign ld_resp_rdata = ld_deliver ? dmem_rdata : '0;
  assign sb_pop        = (state_q == ST_WAIT) && dmem_resp;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rob_d    = rob_q;
    squash_d = squash_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ld) begin
          state_d  = LD_WAIT;
          addr_d   = ld_req_addr;
          rob_d    = ld_req_rob;
          squash_d = 1'b0;
        end else if (grant_st) begin
          state_d = ST_WAIT;
          addr_d  = sb_head_addr;
          wdata_d = sb_head_wdata;
        end
      end
      LD_WAIT: begin
        if (dmem_resp) begin
          state_d  = IDLE;
          squash_d = 1'b0;
        end else if (move_flush) begin
          squash_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rob_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rob_q    <= rob_d;
      squash_q <= squash_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_ld_q, perf_st_q, perf_forced_q, perf_squash_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ld_q     <= '0;
      perf_st_q     <= '0;
      perf_forced_q <= '0;
      perf_squash_q <= '0;
    end else begin
      perf_ld_q     <= sat_inc32(perf_ld_q, grant_ld);
      perf_st_q     <= sat_inc32(perf_st_q, grant_st);
      perf_forced_q <= sat_inc32(perf_forced_q,
                                 grant_st && ld_req_valid && (store_buffer_full || force_store));
      perf_squash_q <= sat_inc32(perf_squash_q, ld_done && !ld_deliver);
    end
  end

  assign perf_ld_grants   = perf_ld_q;
  assign perf_st_grants   = perf_st_q;
  assign perf_forced_st   = perf_forced_q;
  assign perf_squashed_ld = perf_squash_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_dmem_port_arbiter;

  localparam int unsigned ROB_DEPTH    = 3;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned STARVE_W     = 3;
  localparam int          STREAK_MAX   = (1 << STARVE_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 move_flush = 1'b0;
  logic                 ld_req_valid = 1'b0;
  logic [31:0]          ld_req_addr = '0;
  logic [3:0]           ld_req_rmask = '0;
  logic [ROB_DEPTH-1:0] ld_req_rob = '0;
  logic                 ld_req_ready;
  logic                 ld_resp_valid;
  logic [ROB_DEPTH-1:0] ld_resp_rob;
  logic [31:0]          ld_resp_rdata;
  logic                 sb_head_valid = 1'b0;
  logic [31:0]          sb_head_addr = '0;
  logic [3:0]           sb_head_wmask = '0;
  logic [31:0]          sb_head_wdata = '0;
  logic                 store_buffer_full = 1'b0;
  logic                 sb_pop;
  logic [31:0]          dmem_addr;
  logic [3:0]           dmem_rmask;
  logic [3:0]           dmem_wmask;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata = '0;
  logic                 dmem_resp = 1'b0;

  dmem_port_arbiter #(
    .ROB_DEPTH   (ROB_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT),
    .STARVE_W    (STARVE_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .move_flush       (move_flush),
    .ld_req_valid     (ld_req_valid),
    .ld_req_addr      (ld_req_addr),
    .ld_req_rmask     (ld_req_rmask),
    .ld_req_rob       (ld_req_rob),
    .ld_req_ready     (ld_req_ready),
    .ld_resp_valid    (ld_resp_valid),
    .ld_resp_rob      (ld_resp_rob),
    .ld_resp_rdata    (ld_resp_rdata),
    .sb_head_valid    (sb_head_valid),
    .sb_head_addr     (sb_head_addr),
    .sb_head_wmask    (sb_head_wmask),
    .sb_head_wdata    (sb_head_wdata),
    .store_buffer_full(store_buffer_full),
    .sb_pop           (sb_pop),
    .dmem_addr        (dmem_addr),
    .dmem_rmask       (dmem_rmask),
    .dmem_wmask       (dmem_wmask),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 ready;
    logic [3:0]           rmask;
    logic [3:0]           wmask;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic                 rv;
    logic [ROB_DEPTH-1:0] rob;
    logic [31:0]          rdata;
    logic                 pop;
  } obs_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one transaction in flight at most.
  bit                   m_busy, m_load, m_squash;
  logic [31:0]          m_addr, m_wdata;
  logic [ROB_DEPTH-1:0] m_rob;
  int                   m_streak, m_since, m_lat;
  bit                   g_ld, g_st;

  task automatic model_reset();
    m_busy = 0; m_load = 0; m_squash = 0;
    m_addr = '0; m_wdata = '0; m_rob = '0;
    m_streak = 0; m_since = 0; m_lat = 1;
  endtask

  // Samples the DUT mid-cycle, builds the expectation, then advances the model.
  task automatic run_cycle(output obs_t o, output obs_t e);
    bit load_ok, gl, gs;
    @(negedge clk);
    e = '0; gl = 0; gs = 0;
    if (!m_busy) begin
      load_ok = ld_req_valid && !move_flush;
      gs = sb_head_valid && (store_buffer_full || (m_streak >= STARVE_LIMIT) || !load_ok);
      gl = load_ok && !gs;
    end
    e.ready = gl;
    e.rmask = gl ? ld_req_rmask : 4'h0;
    e.wmask = gs ? sb_head_wmask : 4'h0;
    if (gl)          e.addr = ld_req_addr;
    else if (gs)     e.addr = sb_head_addr;
    else if (m_busy) e.addr = m_addr;
    if (gs)                    e.wdata = sb_head_wdata;
    else if (m_busy && !m_load) e.wdata = m_wdata;
    if (m_busy && dmem_resp) begin
      if (m_load) begin
        e.rv = !m_squash && !move_flush;
        if (e.rv) begin
          e.rob   = m_rob;
          e.rdata = dmem_rdata;
        end
      end else begin
        e.pop = 1'b1;
      end
    end
    o.ready = ld_req_ready;
    o.rmask = dmem_rmask;
    o.wmask = dmem_wmask;
    o.addr  = (gl || gs || m_busy) ? dmem_addr : '0;
    o.wdata = (gs || (m_busy && !m_load)) ? dmem_wdata : '0;
    o.rv    = ld_resp_valid;
    o.rob   = ld_resp_valid ? ld_resp_rob : '0;
    o.rdata = ld_resp_valid ? ld_resp_rdata : '0;
    o.pop   = sb_pop;
    g_ld = gl; g_st = gs;
    @(posedge clk);
    if (!m_busy) begin
      if (gl) begin
        m_busy = 1; m_load = 1; m_squash = 0;
        m_addr = ld_req_addr; m_rob = ld_req_rob;
        m_streak = sb_head_valid ? ((m_streak + 1 > STREAK_MAX) ? STREAK_MAX : m_streak + 1) : 0;
      end else if (gs) begin
        m_busy = 1; m_load = 0;
        m_addr = sb_head_addr; m_wdata = sb_head_wdata;
        m_streak = 0;
      end else if (!sb_head_valid) begin
        m_streak = 0;
      end
      if (gl || gs) begin
        m_since = 1;
        m_lat = $urandom_range(1, 3);
      end
    end else begin
      if (dmem_resp) m_busy = 0;
      else begin
        if (m_load && move_flush) m_squash = 1;
        m_since++;
      end
      if (!sb_head_valid) m_streak = 0;
    end
    #1;
  endtask

  task automatic quiesce();
    obs_t o, e;
    ld_req_valid = 0; sb_head_valid = 0; store_buffer_full = 0; move_flush = 0;
    for (int i = 0; i < 6; i++) begin
      dmem_resp = m_busy;
      run_cycle(o, e);
    end
    dmem_resp = 0;
  endtask

  task automatic test_reset();
    ld_req_valid = 1; ld_req_rmask = 4'hF; ld_req_addr = 32'h40;
    sb_head_valid = 1; sb_head_wmask = 4'hF; sb_head_addr = 32'h80; sb_head_wdata = 32'hA5A5A5A5;
    store_buffer_full = 1;
    #12;
    n_cmp++;
    if ({ld_req_ready, ld_resp_valid, sb_pop, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ready=%b rmask=%h wmask=%h addr=%h wdata=%h, want all 0",
               ld_req_ready, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata);
    end
    ld_req_valid = 0; sb_head_valid = 0; store_buffer_full = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_load_only();
    obs_t o, e;
    int pulses;
    quiesce();
    pulses = 0;
    ld_req_valid = 1; ld_req_addr = 32'h100; ld_req_rmask = 4'hF; ld_req_rob = 3'd5;
    run_cycle(o, e);
    n_cmp++;
    if ({o.ready, o.rmask, o.wmask, o.addr} !== {1'b1, 4'hF, 4'h0, 32'h100}) begin
      n_err++;
      $display("FAIL load_only_grant: got ready=%b rmask=%h wmask=%h addr=%h, want 1 f 0 00000100",
               o.ready, o.rmask, o.wmask, o.addr);
    end
    ld_req_valid = 0;
    for (int c = 1; c < 5; c++) begin
      dmem_resp = (c == 2);
      dmem_rdata = (c == 2) ? 32'hDEADBEEF : $urandom;
      run_cycle(o, e);
      pulses += o.rv;
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL load_only_c%0d: got %h want %h", c, o, e);
      end
      if (c == 2) begin
        n_cmp++;
        if ({o.rv, o.rob, o.rdata} !== {1'b1, 3'd5, 32'hDEADBEEF}) begin
          n_err++;
          $display("FAIL load_only_resp: got v=%b rob=%0d data=%h, want 1 5 deadbeef", o.rv, o.rob, o.rdata);
        end
      end
    end
    dmem_resp = 0;
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL load_only_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_simultaneous();
    obs_t o, e;
    int pops;
    quiesce();
    pops = 0;
    ld_req_valid = 1; ld_req_addr = 32'h40; ld_req_rmask = 4'h3; ld_req_rob = 3'd1;
    sb_head_valid = 1; sb_head_addr = 32'h80; sb_head_wmask = 4'hF; sb_head_wdata = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) ld_req_valid = 0;
      if (c == 4) sb_head_valid = 0;
      dmem_resp = (c == 1) || (c == 3);
      dmem_rdata = $urandom;
      run_cycle(o, e);
      pops += o.pop;
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL simult_c%0d: got %h want %h", c, o, e);
      end
      if (c == 0 || c == 2) begin
        n_cmp++;
        if ({o.ready, o.wmask} !== ((c == 0) ? 5'b1_0000 : 5'b0_1111)) begin
          n_err++;
          $display("FAIL simult_order_c%0d: got ready=%b wmask=%h", c, o.ready, o.wmask);
        end
      end
    end
    dmem_resp = 0;
    n_cmp++;
    if (pops != 1) begin
      n_err++;
      $display("FAIL simult_pops: got %0d want 1", pops);
    end
  endtask

  task automatic test_starvation();
    obs_t o, e;
    int loads, stores;
    int run_loads [2];
    quiesce();
    loads = 0; stores = 0;
    run_loads[0] = -1; run_loads[1] = -1;
    ld_req_valid = 1; ld_req_rmask = 4'hF; ld_req_addr = 32'h300; ld_req_rob = 3'd4;
    sb_head_valid = 1; sb_head_addr = 32'h204; sb_head_wmask = 4'h3; sb_head_wdata = $urandom;
    for (int c = 0; c < 60 && stores < 2; c++) begin
      dmem_resp = m_busy;
      run_cycle(o, e);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL starve_c%0d: got %h want %h", c, o, e);
      end
      if (o.ready) loads++;
      if (o.wmask != 4'h0) begin
        run_loads[stores] = loads;
        loads = 0;
        stores++;
        n_cmp++;
        if ({o.wmask, o.addr} !== {4'h3, 32'h204}) begin
          n_err++;
          $display("FAIL starve_store: got wmask=%h addr=%h want 3 00000204", o.wmask, o.addr);
        end
      end
    end
    n_cmp++;
    if (run_loads[0] != 4 || run_loads[1] != 4) begin
      n_err++;
      $display("FAIL starve_count: got %0d,%0d loads before stores, want 4,4", run_loads[0], run_loads[1]);
    end
  endtask

  task automatic test_full();
    obs_t o, e;
    quiesce();
    ld_req_valid = 1; ld_req_rmask = 4'h1; ld_req_addr = 32'h10; ld_req_rob = 3'd6;
    sb_head_valid = 1; sb_head_addr = 32'h500; sb_head_wmask = 4'hC; sb_head_wdata = 32'hCAFEF00D;
    store_buffer_full = 1;
    for (int c = 0; c < 2; c++) begin
      dmem_resp = m_busy;
      run_cycle(o, e);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL full_c%0d: got %h want %h", c, o, e);
      end
      if (c == 0) begin
        n_cmp++;
        if ({o.ready, o.rmask, o.wmask, o.wdata} !== {1'b0, 4'h0, 4'hC, 32'hCAFEF00D}) begin
          n_err++;
          $display("FAIL full_grant: got ready=%b rmask=%h wmask=%h wdata=%h", o.ready, o.rmask, o.wmask, o.wdata);
        end
      end
    end
    store_buffer_full = 0;
  endtask

  task automatic test_flush();
    obs_t o, e;
    int pulses;
    quiesce();
    pulses = 0;
    ld_req_valid = 1; ld_req_rmask = 4'hF; ld_req_addr = 32'h600; ld_req_rob = 3'd2;
    for (int c = 0; c < 8; c++) begin
      ld_req_valid = (c == 0) || (c == 5);
      if (c == 5) ld_req_rob = 3'd3;
      move_flush = (c == 1);
      dmem_resp = (c == 3) || (c == 6);
      dmem_rdata = $urandom;
      run_cycle(o, e);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL flush_c%0d: got %h want %h", c, o, e);
      end
      if (c < 5) pulses += o.rv;
      if (c == 6) begin
        n_cmp++;
        if ({o.rv, o.rob} !== {1'b1, 3'd3}) begin
          n_err++;
          $display("FAIL flush_next_load: got v=%b rob=%0d want 1 3", o.rv, o.rob);
        end
      end
    end
    dmem_resp = 0; move_flush = 0;
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL flush_squash: got %0d responses want 0", pulses);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    quiesce();
    for (int c = 0; c < 600; c++) begin
      ld_req_valid = ($urandom_range(0, 2) != 0);
      ld_req_addr = $urandom & 32'hFFFF_FFFC;
      ld_req_rmask = 4'($urandom_range(1, 15));
      ld_req_rob = 3'($urandom);
      sb_head_valid = $urandom_range(0, 1) != 0;
      sb_head_addr = $urandom & 32'hFFFF_FFFC;
      sb_head_wmask = 4'($urandom_range(1, 15));
      sb_head_wdata = $urandom;
      store_buffer_full = ($urandom_range(0, 4) == 0);
      move_flush = ($urandom_range(0, 7) == 0);
      dmem_rdata = $urandom;
      dmem_resp = m_busy && (m_since >= m_lat);
      run_cycle(o, e);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random_c%0d: got %h want %h", c, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    quiesce();
    sb_head_valid = 1; sb_head_addr = 32'h700; sb_head_wmask = 4'hF; sb_head_wdata = 32'h0BADF00D;
    run_cycle(o, e);
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL areset_grant: got %h want %h", o, e);
    end
    dmem_resp = 1;
    ld_req_valid = 1;
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({ld_req_ready, ld_resp_valid, sb_pop, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata} !== '0) begin
      n_err++;
      $display("FAIL areset_outputs: got pop=%b wmask=%h addr=%h wdata=%h, want all 0",
               sb_pop, dmem_wmask, dmem_addr, dmem_wdata);
    end
    @(posedge clk);
    @(negedge clk);
    sb_head_valid = 0; ld_req_valid = 0;
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (sb_pop !== 1'b0) begin
        n_err++;
        $display("FAIL areset_no_pop_c%0d: got %b want 0", c, sb_pop);
      end
    end
    dmem_resp = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_only();
    test_simultaneous();
    test_starvation();
    test_full();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
